id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//   ID->EX pipeline register of the 5-stage MIPS core. Registers the decode control bundle, operands and extended immediate.
//   Resolves the destination register and detects load-use hazards.
//   On a hazard it inserts one bubble into EX, drives o_nop back into decode control, and stalls PC and IF/ID.
//   Also honours a downstream EX stall and a branch flush.
// PARAMETERS
//   DATA_W  32  register-file / operand width
//   CNT_W   16  width of saturating bubble counter
// PORTS
//   i_clk        in   1       single clock, rising edge
//   i_rst        in   1       synchronous, active-high reset
//   i_flush      in   1       branch/jump redirect: kill instruction entering EX
//   i_ex_stall   in   1       EX/MEM busy: hold ID/EX contents
//   i_ctrl       in   15      decode control bundle (bit map in package)
//   i_opcode     in   6       instruction [31:26]
//   i_funct      in   6       instruction [5:0]
//   i_rs,i_rt,i_rd in 5 each  register specifiers
//   i_shamt      in   5       shift amount
//   i_imm        in   16      instruction [15:0]
//   i_rs_data    in   DATA_W  RF read port A
//   i_rt_data    in   DATA_W  RF read port B
//   o_valid      out  1       EX holds a real instruction
//   o_ctrl       out  15      registered control bundle
//   o_opcode,o_funct out 6    registered
//   o_rs,o_rt    out  5       registered (for forwarding)
//   o_dst        out  5       write-back register; 0 if no write
//   o_shamt      out  5       registered
//   o_rs_data,o_rt_data out DATA_W registered operands
//   o_imm_ext    out  DATA_W  imm sign-extended if i_ctrl[SIGNED_EXT], else zero-extended
//   o_nop        out  1       comb: force decode controls to zero (load-use)
//   o_stall      out  1       comb: hold PC and IF/ID this cycle
//   o_bubble_cnt out  CNT_W   bubbles inserted since reset, saturating
// BEHAVIOUR
//   Reset: every output register 0; o_valid=0; o_bubble_cnt=0.
//   dst: rd if ctrl[RG_WRITE]; else rt if ctrl[RG_WRITE_IMM] or ctrl[MEM_RD]; else 0.
//   uses_rs: all except opcode 0 with funct 0/2/3.
//   uses_rt: opcode 0, or opcode 40/41/43.
//   hazard = o_valid & o_ctrl[MEM_RD] & o_dst!=0 & ((uses_rs & o_dst==i_rs) | (uses_rt & o_dst==i_rt)).
//   o_nop = hazard & ~i_flush & ~i_ex_stall.
//   o_stall = i_ex_stall | (hazard & ~i_flush).
//   Per-edge priority:
//     rst > flush (load bubble) > ex_stall (hold all) > hazard (load bubble, cnt+1) > load inputs, o_valid=1.
//   Bubble: o_valid=0, o_ctrl=0, o_dst=0. Data fields are don't-care but stay deterministic (cleared).
//   Latency 1 cycle. A hazard lasts exactly one cycle: the bubble clears it next cycle.
//   The flush bubble is not counted; the counter saturates at all-ones.
//   No combinational path from i_ctrl to o_nop/o_stall (hazard uses opcode/funct/specifiers only).
// STRUCTURE
//   Package mips_pkg:
//     CTRL_W=15 and bit indices:
//       0 SWAP_RS_SH, 1 SWAP_RS_RT, 2 SWAP_RT_IMM, 3 SIGNED_EXT, 4 MEM_RD,
//       5 RG_WRITE, 6 BYTE_RD, 7 SIGNED_MEM_RD, 8 HALF_RD, 9 WORD_RD,
//       10 MEM_WR, 11 BYTE_WR, 12 HALF_WR, 13 WORD_WR, 14 RG_WRITE_IMM.
//     Opcode constants OP_RTYPE, OP_SB=40, OP_SH=41, OP_SW=43.
//   Sub-module hazard_detect: combinational uses_rs/uses_rt/hazard.
//   Registers, muxing and counter stay in id_ex_stage.
// TESTING
//   1 Reset mid-stream with o_valid=1 -> next edge all outputs 0, o_bubble_cnt=0.
//   2 lw $8 in EX, then add $9,$8,$10 in ID -> o_nop=1, o_stall=1 one cycle;
//     EX gets bubble; cnt=1; add enters EX the following edge.
//   3 lw $8 in EX, then sll $9,$8,2 in ID (rt=8) -> hazard; same with rs=8 on sll -> no hazard.
//   4 lw $0 in EX, then ID uses $0 -> no hazard, no stall.
//   5 i_ex_stall=1 for 3 cycles while a hazard is pending -> contents held, o_nop=0, cnt unchanged;
//     after release the bubble is inserted.
//   6 i_flush=1 together with a hazard -> bubble loaded, o_stall=0, o_nop=0, cnt unchanged;
//     andi imm=16'h8000 -> o_imm_ext=32'h00008000; addi imm=16'h8000 -> 32'hFFFF8000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared decode-control bit map and opcode constants for the 5-stage MIPS core.
package mips_pkg;

    localparam int unsigned CTRL_W = 15;

    localparam int unsigned SWAP_RS_SH    = 0;
    localparam int unsigned SWAP_RS_RT    = 1;
    localparam int unsigned SWAP_RT_IMM   = 2;
    localparam int unsigned SIGNED_EXT    = 3;
    localparam int unsigned MEM_RD        = 4;
    localparam int unsigned RG_WRITE      = 5;
    localparam int unsigned BYTE_RD       = 6;
    localparam int unsigned SIGNED_MEM_RD = 7;
    localparam int unsigned HALF_RD       = 8;
    localparam int unsigned WORD_RD       = 9;
    localparam int unsigned MEM_WR        = 10;
    localparam int unsigned BYTE_WR       = 11;
    localparam int unsigned HALF_WR       = 12;
    localparam int unsigned WORD_WR       = 13;
    localparam int unsigned RG_WRITE_IMM  = 14;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_SB    = 6'd40;
    localparam logic [5:0] OP_SH    = 6'd41;
    localparam logic [5:0] OP_SW    = 6'd43;

    // Constant-shift R-type functs: rs field is unused.
    localparam logic [5:0] FN_SLL = 6'd0;
    localparam logic [5:0] FN_SRL = 6'd2;
    localparam logic [5:0] FN_SRA = 6'd3;

    function automatic logic [4:0] resolve_dst(input logic [CTRL_W-1:0] ctrl,
                                               input logic [4:0]        rt,
                                               input logic [4:0]        rd);
        if (ctrl[RG_WRITE]) begin
            return rd;
        end else if (ctrl[RG_WRITE_IMM] || ctrl[MEM_RD]) begin
            return rt;
        end
        return 5'd0;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: compares the load in EX against the source registers of the
// instruction in ID. Uses only opcode/funct/specifiers from ID, never the decoded controls.
module hazard_detect
    import mips_pkg::*;
(
    input  logic       ex_valid_i,
    input  logic       ex_mem_rd_i,
    input  logic [4:0] ex_dst_i,
    input  logic [5:0] id_opcode_i,
    input  logic [5:0] id_funct_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    output logic       hazard_o
);

    logic uses_rs;
    logic uses_rt;
    logic rs_match;
    logic rt_match;

    always_comb begin
        uses_rs  = !((id_opcode_i == OP_RTYPE) &&
                     ((id_funct_i == FN_SLL) || (id_funct_i == FN_SRL) ||
                      (id_funct_i == FN_SRA)));
        uses_rt  = (id_opcode_i == OP_RTYPE) || (id_opcode_i == OP_SB) ||
                   (id_opcode_i == OP_SH) || (id_opcode_i == OP_SW);
        rs_match = uses_rs && (ex_dst_i == id_rs_i);
        rt_match = uses_rt && (ex_dst_i == id_rt_i);
        hazard_o = ex_valid_i && ex_mem_rd_i && (ex_dst_i != 5'd0) && (rs_match || rt_match);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: captures decode bundle and operands, resolves the write-back
// register, and inserts a bubble on load-use hazards (with stall/flush handling).
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_ex_stall,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [5:0]        i_opcode,
    input  logic [5:0]        i_funct,
    input  logic [4:0]        i_rs,
    input  logic [4:0]        i_rt,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_shamt,
    input  logic [15:0]       i_imm,
    input  logic [DATA_W-1:0] i_rs_data,
    input  logic [DATA_W-1:0] i_rt_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [5:0]        o_opcode,
    output logic [5:0]        o_funct,
    output logic [4:0]        o_rs,
    output logic [4:0]        o_rt,
    output logic [4:0]        o_dst,
    output logic [4:0]        o_shamt,
    output logic [DATA_W-1:0] o_rs_data,
    output logic [DATA_W-1:0] o_rt_data,
    output logic [DATA_W-1:0] o_imm_ext,
    output logic              o_nop,
    output logic              o_stall,
    output logic [CNT_W-1:0]  o_bubble_cnt
);

    logic              valid_q,   valid_d;
    logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
    logic [5:0]        opcode_q,  opcode_d;
    logic [5:0]        funct_q,   funct_d;
    logic [4:0]        rs_q,      rs_d;
    logic [4:0]        rt_q,      rt_d;
    logic [4:0]        dst_q,     dst_d;
    logic [4:0]        shamt_q,   shamt_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic              hazard;
    logic [DATA_W-1:0] imm_ext;

    hazard_detect u_hazard_detect (
        .ex_valid_i  (valid_q),
        .ex_mem_rd_i (ctrl_q[MEM_RD]),
        .ex_dst_i    (dst_q),
        .id_opcode_i (i_opcode),
        .id_funct_i  (i_funct),
        .id_rs_i     (i_rs),
        .id_rt_i     (i_rt),
        .hazard_o    (hazard)
    );

    always_comb begin
        imm_ext = i_ctrl[SIGNED_EXT] ? {{(DATA_W-16){i_imm[15]}}, i_imm}
                                     : {{(DATA_W-16){1'b0}}, i_imm};
    end

    always_comb begin
        o_nop   = hazard && !i_flush && !i_ex_stall;
        o_stall = i_ex_stall || (hazard && !i_flush);
    end

    // Priority: flush bubble > EX hold > hazard bubble (counted) > normal load.
    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        opcode_d  = opcode_q;
        funct_d   = funct_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        dst_d     = dst_q;
        shamt_d   = shamt_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        cnt_d     = cnt_q;

        if (i_flush || (!i_ex_stall && hazard)) begin
            valid_d   = 1'b0;
            ctrl_d    = '0;
            opcode_d  = '0;
            funct_d   = '0;
            rs_d      = '0;
            rt_d      = '0;
            dst_d     = '0;
            shamt_d   = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            if (!i_flush && !(&cnt_q)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (!i_ex_stall) begin
            valid_d   = 1'b1;
            ctrl_d    = i_ctrl;
            opcode_d  = i_opcode;
            funct_d   = i_funct;
            rs_d      = i_rs;
            rt_d      = i_rt;
            dst_d     = resolve_dst(i_ctrl, i_rt, i_rd);
            shamt_d   = i_shamt;
            rs_data_d = i_rs_data;
            rt_data_d = i_rt_data;
            imm_d     = imm_ext;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            opcode_q  <= '0;
            funct_q   <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            dst_q     <= '0;
            shamt_q   <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            opcode_q  <= opcode_d;
            funct_q   <= funct_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            dst_q     <= dst_d;
            shamt_q   <= shamt_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_ctrl       = ctrl_q;
    assign o_opcode     = opcode_q;
    assign o_funct      = funct_q;
    assign o_rs         = rs_q;
    assign o_rt         = rt_q;
    assign o_dst        = dst_q;
    assign o_shamt      = shamt_q;
    assign o_rs_data    = rs_data_q;
    assign o_rt_data    = rt_data_q;
    assign o_imm_ext    = imm_q;
    assign o_bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: hand vectors, directed corner sequences and a
// randomized run against a behavioural model; a narrow-counter instance checks saturation.
module tb_id_ex_stage;

    localparam int unsigned SAT_W = 3;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        stall;
        logic [14:0] ctrl;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [15:0] imm;
        logic [31:0] a;
        logic [31:0] b;
    } in_t;

    typedef struct {
        logic        valid;
        logic [14:0] ctrl;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [4:0]  sh;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } ex_t;

    typedef struct {
        string       name;
        in_t         ex_in;
        in_t         id_in;
        logic [4:0]  exp_dst;
        logic        exp_haz;
    } vec_t;

    localparam logic [14:0] C_LW  = 15'h4218; // RG_WRITE_IMM|WORD_RD|MEM_RD|SIGNED_EXT
    localparam logic [14:0] C_ADD = 15'h0020; // RG_WRITE
    localparam logic [14:0] C_SW  = 15'h2408; // WORD_WR|MEM_WR|SIGNED_EXT

    logic        clk = 1'b0;
    logic        rst, flush, ex_stall;
    logic [14:0] ctrl;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] rs_data, rt_data;

    logic        o_valid, o_nop, o_stall;
    logic [14:0] o_ctrl;
    logic [5:0]  o_opcode, o_funct;
    logic [4:0]  o_rs, o_rt, o_dst, o_shamt;
    logic [31:0] o_rs_data, o_rt_data, o_imm_ext;
    logic [15:0] o_bubble_cnt;

    logic        s_valid, s_nop, s_stall;
    logic [14:0] s_ctrl;
    logic [5:0]  s_opcode, s_funct;
    logic [4:0]  s_rs, s_rt, s_dst, s_shamt;
    logic [31:0] s_rs_data, s_rt_data, s_imm_ext;
    logic [SAT_W-1:0] s_bubble_cnt;

    int checks = 0;
    int errors = 0;

    ex_t         m;
    int unsigned m_cnt;
    in_t         cur;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_ex_stall(ex_stall), .i_ctrl(ctrl),
        .i_opcode(opcode), .i_funct(funct), .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_shamt(shamt),
        .i_imm(imm), .i_rs_data(rs_data), .i_rt_data(rt_data),
        .o_valid(o_valid), .o_ctrl(o_ctrl), .o_opcode(o_opcode), .o_funct(o_funct),
        .o_rs(o_rs), .o_rt(o_rt), .o_dst(o_dst), .o_shamt(o_shamt), .o_rs_data(o_rs_data),
        .o_rt_data(o_rt_data), .o_imm_ext(o_imm_ext), .o_nop(o_nop), .o_stall(o_stall),
        .o_bubble_cnt(o_bubble_cnt)
    );

    id_ex_stage #(.DATA_W(32), .CNT_W(SAT_W)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_ex_stall(ex_stall), .i_ctrl(ctrl),
        .i_opcode(opcode), .i_funct(funct), .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_shamt(shamt),
        .i_imm(imm), .i_rs_data(rs_data), .i_rt_data(rt_data),
        .o_valid(s_valid), .o_ctrl(s_ctrl), .o_opcode(s_opcode), .o_funct(s_funct),
        .o_rs(s_rs), .o_rt(s_rt), .o_dst(s_dst), .o_shamt(s_shamt), .o_rs_data(s_rs_data),
        .o_rt_data(s_rt_data), .o_imm_ext(s_imm_ext), .o_nop(s_nop), .o_stall(s_stall),
        .o_bubble_cnt(s_bubble_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input logic [14:0] c, input logic [5:0] op, input logic [5:0] fn,
                               input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        in_t r;
        r.rst = 1'b0; r.flush = 1'b0; r.stall = 1'b0;
        r.ctrl = c; r.op = op; r.fn = fn; r.rs = s; r.rt = t; r.rd = d;
        r.sh = 5'd2; r.imm = 16'h1234;
        r.a = 32'hA000_0000 | 32'(s); r.b = 32'hB000_0000 | 32'(t);
        return r;
    endfunction

    // Reference rules, written straight from the instruction semantics.
    function automatic logic [4:0] ref_dst(input in_t in);
        if (in.ctrl[5]) return in.rd;
        if (in.ctrl[14] || in.ctrl[4]) return in.rt;
        return 5'd0;
    endfunction

    function automatic bit ref_hazard(input ex_t e, input in_t in);
        bit shift_const = (in.op == 6'd0) && (in.fn == 6'd0 || in.fn == 6'd2 || in.fn == 6'd3);
        bit reads_rs = !shift_const;
        bit reads_rt = (in.op == 6'd0) || (in.op == 6'd40) || (in.op == 6'd41) || (in.op == 6'd43);
        if (!e.valid || !e.ctrl[4] || e.dst == 5'd0) return 1'b0;
        return (reads_rs && e.dst == in.rs) || (reads_rt && e.dst == in.rt);
    endfunction

    task automatic apply(input in_t in);
        bit h;
        @(negedge clk);
        cur = in;
        rst = in.rst; flush = in.flush; ex_stall = in.stall; ctrl = in.ctrl;
        opcode = in.op; funct = in.fn; rs = in.rs; rt = in.rt; rd = in.rd; shamt = in.sh;
        imm = in.imm; rs_data = in.a; rt_data = in.b;
        #1;
        h = ref_hazard(m, in);
        check("nop", 64'(o_nop), 64'(h && !in.flush && !in.stall));
        check("stall", 64'(o_stall), 64'(in.stall || (h && !in.flush)));
    endtask

    task automatic tick();
        bit h;
        ex_t z;
        z = '{default: '0};
        @(posedge clk);
        h = ref_hazard(m, cur);
        if (cur.rst) begin
            m = z; m_cnt = 0;
        end else if (cur.flush) begin
            m = z;
        end else if (cur.stall) begin
            m = m;
        end else if (h) begin
            m = z; m_cnt++;
        end else begin
            m.valid = 1'b1; m.ctrl = cur.ctrl; m.op = cur.op; m.fn = cur.fn;
            m.rs = cur.rs; m.rt = cur.rt; m.dst = ref_dst(cur); m.sh = cur.sh;
            m.a = cur.a; m.b = cur.b;
            m.imm = cur.ctrl[3] ? 32'($signed(cur.imm)) : 32'(cur.imm);
        end
        #1;
        check("valid", 64'(o_valid), 64'(m.valid));
        check("ctrl", 64'(o_ctrl), 64'(m.ctrl));
        check("opcode", 64'(o_opcode), 64'(m.op));
        check("funct", 64'(o_funct), 64'(m.fn));
        check("rs", 64'(o_rs), 64'(m.rs));
        check("rt", 64'(o_rt), 64'(m.rt));
        check("dst", 64'(o_dst), 64'(m.dst));
        check("shamt", 64'(o_shamt), 64'(m.sh));
        check("rs_data", 64'(o_rs_data), 64'(m.a));
        check("rt_data", 64'(o_rt_data), 64'(m.b));
        check("imm_ext", 64'(o_imm_ext), 64'(m.imm));
        check("bubble_cnt", 64'(o_bubble_cnt), 64'(m_cnt > 65535 ? 65535 : m_cnt));
        check("sat_cnt", 64'(s_bubble_cnt), 64'(m_cnt > 7 ? 7 : m_cnt));
    endtask

    task automatic do_reset();
        in_t r;
        r = mk(15'd0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
        r.rst = 1'b1;
        apply(r);
        tick();
    endtask

    initial begin
        vec_t vecs[10];
        in_t  lw8, add98, x;
        int   n;
        logic [4:0] regs[4];

        m = '{default: '0};
        m_cnt = 0;
        lw8   = mk(C_LW, 6'd35, 6'd0, 5'd9, 5'd8, 5'd0);
        add98 = mk(C_ADD, 6'd0, 6'h20, 5'd8, 5'd10, 5'd9);

        vecs[0] = '{"lw_add_rs",   lw8, add98, 5'd8, 1'b1};
        vecs[1] = '{"lw_sll_rt",   lw8, mk(C_ADD, 6'd0, 6'd0, 5'd0, 5'd8, 5'd9), 5'd8, 1'b1};
        vecs[2] = '{"lw_sll_rs",   lw8, mk(C_ADD, 6'd0, 6'd0, 5'd8, 5'd10, 5'd9), 5'd8, 1'b0};
        vecs[3] = '{"lw_zero",     mk(C_LW, 6'd35, 6'd0, 5'd9, 5'd0, 5'd0),
                    mk(C_ADD, 6'd0, 6'h20, 5'd0, 5'd0, 5'd9), 5'd0, 1'b0};
        vecs[4] = '{"add_not_ld",  mk(C_ADD, 6'd0, 6'h20, 5'd1, 5'd2, 5'd8), add98, 5'd8, 1'b0};
        vecs[5] = '{"lw_sw_rt",    lw8, mk(C_SW, 6'd43, 6'd0, 5'd9, 5'd8, 5'd0), 5'd8, 1'b1};
        vecs[6] = '{"lw_addi_rt",  lw8, mk(15'h4008, 6'd8, 6'd0, 5'd9, 5'd8, 5'd0), 5'd8, 1'b0};
        vecs[7] = '{"lw_beq_rt",   lw8, mk(15'd0, 6'd4, 6'd0, 5'd9, 5'd8, 5'd0), 5'd8, 1'b0};
        vecs[8] = '{"lw_jr_rs",    lw8, mk(15'd0, 6'd0, 6'd8, 5'd8, 5'd0, 5'd0), 5'd8, 1'b1};
        vecs[9] = '{"sw_no_dst",   mk(C_SW, 6'd43, 6'd0, 5'd9, 5'd8, 5'd0), add98, 5'd0, 1'b0};

        do_reset();

        // Table-driven: instruction into EX, then probe the one in ID.
        for (int i = 0; i < 10; i++) begin
            apply(mk(15'd0, 6'd0, 6'h20, 5'd0, 5'd0, 5'd0));
            tick();
            apply(vecs[i].ex_in);
            tick();
            check({vecs[i].name, "_dst"}, 64'(o_dst), 64'(vecs[i].exp_dst));
            apply(vecs[i].id_in);
            check({vecs[i].name, "_haz"}, 64'(o_nop), 64'(vecs[i].exp_haz));
            tick();
        end

        // Reset mid-stream with a live instruction in EX.
        apply(add98);
        tick();
        check("pre_rst_valid", 64'(o_valid), 64'd1);
        do_reset();
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_dst", 64'(o_dst), 64'd0);
        check("rst_data", 64'(o_rs_data), 64'd0);
        check("rst_cnt", 64'(o_bubble_cnt), 64'd0);

        // Load-use: one bubble, then the add proceeds.
        apply(lw8); tick();
        apply(add98);
        check("lu_nop", 64'(o_nop), 64'd1);
        check("lu_stall", 64'(o_stall), 64'd1);
        tick();
        check("lu_bubble", 64'(o_valid), 64'd0);
        check("lu_cnt", 64'(o_bubble_cnt), 64'd1);
        apply(add98);
        check("lu_clear", 64'(o_stall), 64'd0);
        tick();
        check("lu_add_valid", 64'(o_valid), 64'd1);
        check("lu_add_dst", 64'(o_dst), 64'd9);

        // EX stall holds a pending hazard for three cycles.
        do_reset();
        apply(lw8); tick();
        x = add98; x.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(x);
            check("st_nop", 64'(o_nop), 64'd0);
            check("st_stall", 64'(o_stall), 64'd1);
            tick();
            check("st_hold_dst", 64'(o_dst), 64'd8);
            check("st_cnt", 64'(o_bubble_cnt), 64'd0);
        end
        apply(add98);
        check("st_rel_nop", 64'(o_nop), 64'd1);
        tick();
        check("st_rel_bubble", 64'(o_valid), 64'd0);
        check("st_rel_cnt", 64'(o_bubble_cnt), 64'd1);

        // Flush coinciding with a hazard; then immediate extension.
        do_reset();
        apply(lw8); tick();
        x = add98; x.flush = 1'b1;
        apply(x);
        check("fl_stall", 64'(o_stall), 64'd0);
        check("fl_nop", 64'(o_nop), 64'd0);
        tick();
        check("fl_valid", 64'(o_valid), 64'd0);
        check("fl_cnt", 64'(o_bubble_cnt), 64'd0);
        x = mk(15'h4000, 6'd12, 6'd0, 5'd9, 5'd10, 5'd0); x.imm = 16'h8000;
        apply(x); tick();
        check("andi_imm", 64'(o_imm_ext), 64'h0000_8000);
        x = mk(15'h4008, 6'd8, 6'd0, 5'd9, 5'd10, 5'd0); x.imm = 16'h8000;
        apply(x); tick();
        check("addi_imm", 64'(o_imm_ext), 64'hFFFF_8000);

        // Randomized run against the model.
        regs[0] = 5'd0; regs[1] = 5'd8; regs[2] = 5'd9; regs[3] = 5'd10;
        n = 2000;
        for (int i = 0; i < n; i++) begin
            logic [5:0] ops[7];
            logic [5:0] fns[5];
            ops[0] = 6'd0; ops[1] = 6'd35; ops[2] = 6'd43; ops[3] = 6'd40;
            ops[4] = 6'd8; ops[5] = 6'd12; ops[6] = 6'd4;
            fns[0] = 6'd0; fns[1] = 6'd2; fns[2] = 6'd3; fns[3] = 6'h20; fns[4] = 6'd8;
            x.rst   = ($urandom_range(0, 499) == 0);
            x.flush = ($urandom_range(0, 9) == 0);
            x.stall = ($urandom_range(0, 7) == 0);
            x.ctrl  = 15'($urandom);
            x.ctrl[4] = ($urandom_range(0, 1) == 1);
            x.op    = ops[$urandom_range(0, 6)];
            x.fn    = fns[$urandom_range(0, 4)];
            x.rs    = regs[$urandom_range(0, 3)];
            x.rt    = regs[$urandom_range(0, 3)];
            x.rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : regs[$urandom_range(0, 3)];
            x.sh    = 5'($urandom);
            x.imm   = 16'($urandom);
            x.a     = $urandom;
            x.b     = $urandom;
            apply(x);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
